// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose:
//   Hazard and sequencing control for a 5-stage pipeline. It controls the PC
//   write enable and the IF/ID and ID/EX pipeline registers. It handles three
//   cases:
//     - a load-use hazard between the instruction in EX and the one in ID,
//       which causes a one-cycle stall,
//     - a taken branch resolved in EX, which flushes IF/ID and ID/EX,
//     - a fixed-latency multiply that occupies EX, which holds the front of
//       the pipe for MUL_LAT-1 cycles.
//
// Parameters:
//   MUL_LAT  EX-stage multiply latency in cycles, 1..15 (1 = no stall)
//   CNT_W    width of the optional performance counters
//
// Ports:
//   clk          in   clock, all state on posedge
//   res          in   asynchronous active-low reset
//   id_rs/id_rt  in   source registers of the instruction in ID
//   id_uses_rs   in   ID instruction reads id_rs
//   id_uses_rt   in   ID instruction reads id_rt
//   id_is_mul    in   ID instruction is a multi-cycle multiply
//   ex_rd        in   destination register of the instruction in EX
//   ex_memread   in   EX instruction is a load
//   ex_regwrite  in   EX instruction writes ex_rd
//   br_taken     in   branch/jump in EX resolved taken this cycle
//   pc_we        out  PC updates this edge
//   ifid_flag    out  IF/ID holds its contents (0 = load)
//   ifid_flush   out  IF/ID loads a NOP this edge
//   idex_bubble  out  ID/EX loads a NOP this edge
//   ex_hold      out  ID/EX and EX/MEM hold (multiply in progress)
//   busy         out  multiply sequencer is in MUL_BUSY
//
// Optional feature (macro HAZARD_PERF_EN):
//   When the macro is defined, the module has two extra outputs.
//   stall_cnt counts cycles with pc_we=0 while out of reset. flush_cnt counts
//   taken-branch flushes. Both counters saturate at all-ones, and res clears
//   both asynchronously. When the macro is undefined, these ports do not exist.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             res,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_mul,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic             br_taken,
  output logic             pc_we,
  output logic             ifid_flag,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             ex_hold,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             busy
);

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  // The counter is loaded with MUL_LAT-1. The sequencer leaves MUL_BUSY on
  // the cycle where cnt_q is 1, so the stall lasts exactly MUL_LAT-1 cycles.
  localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

  state_t     st_q, st_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu_hz;
  logic       br_flush;

  // A load hazard is raised only when ex_rd is a real register. A load whose
  // destination is register 0 never produces a value that ID can use.
  assign lu_hz = ex_memread & ex_regwrite & (ex_rd != 5'd0) &
                 ((id_uses_rs & (id_rs == ex_rd)) |
                  (id_uses_rt & (id_rt == ex_rd)));

  // A branch can resolve only while EX is advancing normally.
  assign br_flush = res & (st_q == RUN) & br_taken;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      st_q  <= RUN;
      cnt_q <= 4'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    pc_we       = 1'b1;
    ifid_flag   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;

    case (st_q)
      RUN: begin
        if (br_taken) begin
          // Squash both younger instructions. A multiply sitting in ID is
          // among them, so the sequencer stays in RUN.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (lu_hz) begin
          // Hold PC and IF/ID for one cycle and send a bubble into EX. The
          // hazard clears on its own once the load moves on to MEM.
          pc_we       = 1'b0;
          ifid_flag   = 1'b1;
          idex_bubble = 1'b1;
        end else if (id_is_mul) begin
          // The multiply enters EX this edge. From the next cycle on, the
          // front of the pipe waits while the multiplier works.
          if (MUL_LAT > 1) begin
            st_d  = MUL_BUSY;
            cnt_d = MUL_INIT;
          end
        end
      end

      MUL_BUSY: begin
        pc_we     = 1'b0;
        ifid_flag = 1'b1;
        ex_hold   = 1'b1;
        if (cnt_q <= 4'd1) begin
          st_d  = RUN;
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        st_d  = RUN;
        cnt_d = 4'd0;
      end
    endcase

    // While reset is asserted, the pipe is held empty and the PC is frozen.
    if (!res) begin
      pc_we       = 1'b0;
      ifid_flag   = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      ex_hold     = 1'b0;
    end
  end

  assign busy = (st_q == MUL_BUSY);

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // pc_we is already forced low during reset. That does not matter here,
  // because the asynchronous clear takes priority over any increment.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_we && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (br_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // Without the counters, br_flush has no consumer.
  logic unused_br_flush;
  assign unused_br_flush = br_flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 32;

  logic       clk;
  logic       res;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, id_is_mul;
  logic       ex_memread, ex_regwrite, br_taken;
  logic       pc_we, ifid_flag, ifid_flush, idex_bubble, ex_hold, busy;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int vectors    = 0;
  int miscompares = 0;

  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .res         (res),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_is_mul   (id_is_mul),
    .ex_rd       (ex_rd),
    .ex_memread  (ex_memread),
    .ex_regwrite (ex_regwrite),
    .br_taken    (br_taken),
    .pc_we       (pc_we),
    .ifid_flag   (ifid_flag),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .ex_hold     (ex_hold),
`ifdef HAZARD_PERF_EN
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vector order: {pc_we, ifid_flag, ifid_flush, idex_bubble, ex_hold, busy}
  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] got;
    got = {pc_we, ifid_flag, ifid_flush, idex_bubble, ex_hold, busy};
    vectors++;
    assert (got === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
    $display("vec %0d %s: {pc_we,flag,flush,bubble,hold,busy}=%b", vectors, tag, got);
  endtask

`ifdef HAZARD_PERF_EN
  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] got,
                         input logic [CNT_W-1:0] exp);
    vectors++;
    assert (got === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
    $display("vec %0d %s: count=%0d", vectors, tag, got);
  endtask
`endif

  task automatic clear_ex();
    ex_memread  = 1'b0;
    ex_regwrite = 1'b0;
    ex_rd       = 5'd0;
  endtask

  initial begin
    res = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_mul = 1'b0;
    ex_memread = 1'b0; ex_regwrite = 1'b0; br_taken = 1'b0;

    // Reset held for three cycles
    repeat (3) tick();
    #3 chk("rst_hold", 6'b001100);
`ifdef HAZARD_PERF_EN
    chk_cnt("rst_stall_cnt", stall_cnt, '0);
    chk_cnt("rst_flush_cnt", flush_cnt, '0);
`endif
    res = 1'b1;
    tick();
    #3 chk("post_rst", 6'b100000);

    // Load-use on rs: one stall cycle
    tick();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5;
    id_rs = 5'd5; id_uses_rs = 1'b1;
    #3 chk("lu_rs", 6'b010100);
    tick();
    clear_ex();   // bubble now in EX
    #3 chk("lu_clear", 6'b100000);
`ifdef HAZARD_PERF_EN
    chk_cnt("lu_stall_cnt", stall_cnt, 32'd1);
`endif

    // Register 0 never hazards
    tick();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    #3 chk("lu_r0", 6'b100000);
    // Matching register but not read
    tick();
    ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b0;
    #3 chk("lu_nouse", 6'b100000);
    // Hazard via rt
    tick();
    id_rt = 5'd5; id_uses_rt = 1'b1;
    #3 chk("lu_rt", 6'b010100);
    // Load that does not write a register
    tick();
    ex_regwrite = 1'b0;
    #3 chk("lu_noregwr", 6'b100000);

    // Branch beats a simultaneous load-use hazard
    tick();
    ex_regwrite = 1'b1; br_taken = 1'b1;
    #3 chk("br_lu", 6'b101100);
    tick();
    br_taken = 1'b0; clear_ex(); id_uses_rt = 1'b0;
    #3 chk("br_after", 6'b100000);
`ifdef HAZARD_PERF_EN
    chk_cnt("br_flush_cnt", flush_cnt, 32'd1);
`endif

    // Multiply: issue cycle, then MUL_LAT-1 = 3 busy cycles
    tick();
    id_is_mul = 1'b1;
    #3 chk("mul_issue", 6'b100000);
    tick();
    id_is_mul = 1'b0;
    #3 chk("mul_busy1", 6'b010011);
    tick();
    br_taken = 1'b1;   // must be ignored while busy
    #3 chk("mul_busy2_br", 6'b010011);
    tick();
    br_taken = 1'b0;
    #3 chk("mul_busy3", 6'b010011);
    // Back-to-back: second multiply issues on the first RUN cycle
    tick();
    id_is_mul = 1'b1;
    #3 chk("mul_b2b_issue", 6'b100000);
`ifdef HAZARD_PERF_EN
    chk_cnt("mul_flush_cnt", flush_cnt, 32'd1);
`endif
    tick();
    id_is_mul = 1'b0;
    #3 chk("mul2_busy1", 6'b010011);

    // Reset during the second busy cycle aborts to RUN
    tick();
    #1 res = 1'b0;
    #1 chk("rst_mid_mul", 6'b001100);
`ifdef HAZARD_PERF_EN
    chk_cnt("rst_mid_stall_cnt", stall_cnt, '0);
`endif
    tick();
    res = 1'b1;
    #3 chk("rst_release", 6'b100000);
    tick();
    #3 chk("still_run", 6'b100000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
